// File: rtl/parser_pkg.sv
// Shared types for the ITCH decoder arbiter: default field widths, canonical record layout, channel select helper.
package parser_pkg;
   localparam int DEF_TYPE_W  = 4;
   localparam int DEF_REF_W   = 64;
   localparam int DEF_QTY_W   = 32;
   localparam int DEF_PRICE_W = 32;
   localparam int DEF_TS_W    = 48;
   localparam int DEF_MISC_W  = 64;
   localparam int DEF_SRC_W   = 3;
   localparam int MAX_CH      = 16;
   localparam int SEL_W       = 4;

   typedef struct packed {
      logic [DEF_TYPE_W-1:0]  typ;
      logic [DEF_REF_W-1:0]   order_ref;
      logic                   side;
      logic [DEF_QTY_W-1:0]   shares;
      logic [DEF_PRICE_W-1:0] price;
      logic [DEF_REF_W-1:0]   new_order_ref;
      logic [DEF_TS_W-1:0]    timestamp;
      logic [DEF_MISC_W-1:0]  misc;
      logic [DEF_SRC_W-1:0]   src;
   } canonical_rec_t;

   typedef struct packed {
      logic [SEL_W-1:0] idx;
      logic             one;
      logic             multi;
   } sel_t;

   // idx is the lowest asserted channel, so collisions resolve toward channel 0.
   function automatic sel_t onehot_sel(input logic [MAX_CH-1:0] v);
      sel_t s;
      int   cnt;
      s   = '0;
      cnt = 0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (v[i]) begin
            s.idx = i[SEL_W-1:0];
            cnt++;
         end
      end
      s.one   = (cnt == 1);
      s.multi = (cnt > 1);
      return s;
   endfunction
endpackage

// File: rtl/canonical_fifo.sv
// Synchronous FIFO for packed canonical records; head visible one cycle after push into an empty FIFO.
// A push while full is accepted only if the head pops in the same cycle, otherwise it is dropped.
module canonical_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop_rdy,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         out_vld,
   output logic         push_acc,
   output logic         push_drop,
   output logic [AW:0]  level
);
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         full, empty, pop;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign empty     = (wr_q == rd_q);
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop       = !empty && pop_rdy;
   assign push_acc  = push && (!full || pop);
   assign push_drop = push && full && !pop;
   assign dout      = mem_q[rd_q[AW-1:0]];
   assign out_vld   = !empty;
   assign level     = wr_q - rd_q;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push_acc) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d                = wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end
endmodule

// File: rtl/parser_arb_fifo.sv
// Picks the single valid ITCH decoder channel into a valid/ready FIFO, 1-cycle latency, drops on full or collision.
// Define PARSER_COLLISION_PRIORITY_EN to push the lowest-index channel on a collision instead of dropping it.
module parser_arb_fifo
   import parser_pkg::*;
#(
   parameter  int NUM_CH  = 6,
   parameter  int DEPTH   = 4,
   parameter  int TYPE_W  = DEF_TYPE_W,
   parameter  int REF_W   = DEF_REF_W,
   parameter  int QTY_W   = DEF_QTY_W,
   parameter  int PRICE_W = DEF_PRICE_W,
   parameter  int TS_W    = DEF_TS_W,
   parameter  int MISC_W  = DEF_MISC_W,
   parameter  int CNT_W   = 16,
   localparam int SRC_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W   = $clog2(DEPTH) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic [NUM_CH-1:0]           ch_valid,
   input  logic [NUM_CH*TYPE_W-1:0]    ch_type,
   input  logic [NUM_CH*REF_W-1:0]     ch_order_ref,
   input  logic [NUM_CH-1:0]           ch_side,
   input  logic [NUM_CH*QTY_W-1:0]     ch_shares,
   input  logic [NUM_CH*PRICE_W-1:0]   ch_price,
   input  logic [NUM_CH*REF_W-1:0]     ch_new_order_ref,
   input  logic [NUM_CH*TS_W-1:0]      ch_timestamp,
   input  logic [NUM_CH*MISC_W-1:0]    ch_misc,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [TYPE_W-1:0]           out_type,
   output logic [REF_W-1:0]            out_order_ref,
   output logic                        out_side,
   output logic [QTY_W-1:0]            out_shares,
   output logic [PRICE_W-1:0]          out_price,
   output logic [REF_W-1:0]            out_new_order_ref,
   output logic [TS_W-1:0]             out_timestamp,
   output logic [MISC_W-1:0]           out_misc,
   output logic [SRC_W-1:0]            out_src,
   output logic [LVL_W-1:0]            fifo_level,
   output logic [CNT_W-1:0]            msg_cnt,
   output logic [CNT_W-1:0]            collision_cnt,
   output logic [CNT_W-1:0]            overflow_cnt,
   output logic                        collision_err,
   output logic                        overflow_err,
   input  logic                        clr_stats
);
   // Same layout as canonical_rec_t, sized by this instance's parameters.
   typedef struct packed {
      logic [TYPE_W-1:0]  typ;
      logic [REF_W-1:0]   order_ref;
      logic               side;
      logic [QTY_W-1:0]   shares;
      logic [PRICE_W-1:0] price;
      logic [REF_W-1:0]   new_order_ref;
      logic [TS_W-1:0]    timestamp;
      logic [MISC_W-1:0]  misc;
      logic [SRC_W-1:0]   src;
   } rec_t;

   logic [MAX_CH-1:0] v_ext;
   sel_t              sel;
   logic [SRC_W-1:0]  src_idx;
   int                src_i;
   rec_t              rec_d, head;
   logic              push, collide, push_acc, push_drop;

   logic [CNT_W-1:0]  msg_cnt_q, msg_cnt_d, collision_cnt_q, collision_cnt_d;
   logic [CNT_W-1:0]  overflow_cnt_q, overflow_cnt_d;
   logic              collision_err_q, collision_err_d, overflow_err_q, overflow_err_d;

   always_comb begin
      v_ext               = '0;
      v_ext[NUM_CH-1:0]   = ch_valid;
      sel                 = onehot_sel(v_ext);
      src_idx             = SRC_W'(sel.idx);
      src_i               = int'(src_idx);
      rec_d.typ           = ch_type[src_i*TYPE_W +: TYPE_W];
      rec_d.order_ref     = ch_order_ref[src_i*REF_W +: REF_W];
      rec_d.side          = ch_side[src_i];
      rec_d.shares        = ch_shares[src_i*QTY_W +: QTY_W];
      rec_d.price         = ch_price[src_i*PRICE_W +: PRICE_W];
      rec_d.new_order_ref = ch_new_order_ref[src_i*REF_W +: REF_W];
      rec_d.timestamp     = ch_timestamp[src_i*TS_W +: TS_W];
      rec_d.misc          = ch_misc[src_i*MISC_W +: MISC_W];
      rec_d.src           = src_idx;
      collide             = valid_in && sel.multi;
`ifdef PARSER_COLLISION_PRIORITY_EN
      push                = valid_in && (sel.one || sel.multi);
`else
      push                = valid_in && sel.one;
`endif
   end

   canonical_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop_rdy   (out_ready),
      .din       (rec_d),
      .dout      (head),
      .out_vld   (out_valid),
      .push_acc  (push_acc),
      .push_drop (push_drop),
      .level     (fifo_level)
   );

   // Counters stick at all-ones; clr_stats overrides any same-cycle event.
   always_comb begin
      msg_cnt_d       = msg_cnt_q;
      collision_cnt_d = collision_cnt_q;
      overflow_cnt_d  = overflow_cnt_q;
      collision_err_d = collision_err_q | collide;
      overflow_err_d  = overflow_err_q | push_drop;
      if (push_acc && (msg_cnt_q != '1))       msg_cnt_d       = msg_cnt_q + 1'b1;
      if (collide && (collision_cnt_q != '1))  collision_cnt_d = collision_cnt_q + 1'b1;
      if (push_drop && (overflow_cnt_q != '1)) overflow_cnt_d  = overflow_cnt_q + 1'b1;
      if (clr_stats) begin
         msg_cnt_d       = '0;
         collision_cnt_d = '0;
         overflow_cnt_d  = '0;
         collision_err_d = 1'b0;
         overflow_err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msg_cnt_q       <= '0;
         collision_cnt_q <= '0;
         overflow_cnt_q  <= '0;
         collision_err_q <= 1'b0;
         overflow_err_q  <= 1'b0;
      end else begin
         msg_cnt_q       <= msg_cnt_d;
         collision_cnt_q <= collision_cnt_d;
         overflow_cnt_q  <= overflow_cnt_d;
         collision_err_q <= collision_err_d;
         overflow_err_q  <= overflow_err_d;
      end
   end

   assign out_type          = head.typ;
   assign out_order_ref     = head.order_ref;
   assign out_side          = head.side;
   assign out_shares        = head.shares;
   assign out_price         = head.price;
   assign out_new_order_ref = head.new_order_ref;
   assign out_timestamp     = head.timestamp;
   assign out_misc          = head.misc;
   assign out_src           = head.src;
   assign msg_cnt           = msg_cnt_q;
   assign collision_cnt     = collision_cnt_q;
   assign overflow_cnt      = overflow_cnt_q;
   assign collision_err     = collision_err_q;
   assign overflow_err      = overflow_err_q;
endmodule

// File: tb/tb_parser_arb_fifo.sv
// Directed bench for parser_arb_fifo: NUM_CH=6, DEPTH=4, CNT_W=4 so counter saturation is reachable.
module tb_parser_arb_fifo;
   localparam int NUM_CH = 6;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  valid_in;
   logic [NUM_CH-1:0]     ch_valid;
   logic [NUM_CH*4-1:0]   ch_type;
   logic [NUM_CH*64-1:0]  ch_order_ref;
   logic [NUM_CH-1:0]     ch_side;
   logic [NUM_CH*32-1:0]  ch_shares;
   logic [NUM_CH*32-1:0]  ch_price;
   logic [NUM_CH*64-1:0]  ch_new_order_ref;
   logic [NUM_CH*48-1:0]  ch_timestamp;
   logic [NUM_CH*64-1:0]  ch_misc;
   logic                  out_valid;
   logic                  out_ready;
   logic [3:0]            out_type;
   logic [63:0]           out_order_ref;
   logic                  out_side;
   logic [31:0]           out_shares;
   logic [31:0]           out_price;
   logic [63:0]           out_new_order_ref;
   logic [47:0]           out_timestamp;
   logic [63:0]           out_misc;
   logic [2:0]            out_src;
   logic [2:0]            fifo_level;
   logic [CNT_W-1:0]      msg_cnt, collision_cnt, overflow_cnt;
   logic                  collision_err, overflow_err;
   logic                  clr_stats;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   parser_arb_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ch_valid(ch_valid),
      .ch_type(ch_type), .ch_order_ref(ch_order_ref), .ch_side(ch_side),
      .ch_shares(ch_shares), .ch_price(ch_price), .ch_new_order_ref(ch_new_order_ref),
      .ch_timestamp(ch_timestamp), .ch_misc(ch_misc),
      .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
      .out_order_ref(out_order_ref), .out_side(out_side), .out_shares(out_shares),
      .out_price(out_price), .out_new_order_ref(out_new_order_ref),
      .out_timestamp(out_timestamp), .out_misc(out_misc), .out_src(out_src),
      .fifo_level(fifo_level), .msg_cnt(msg_cnt), .collision_cnt(collision_cnt),
      .overflow_cnt(overflow_cnt), .collision_err(collision_err),
      .overflow_err(overflow_err), .clr_stats(clr_stats)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      valid_in = 1'b0; ch_valid = '0; ch_type = '0; ch_order_ref = '0; ch_side = '0;
      ch_shares = '0; ch_price = '0; ch_new_order_ref = '0; ch_timestamp = '0; ch_misc = '0;
   endtask

   task automatic push_ch(input int ch, input int shares);
      ch_valid                = '0;
      ch_valid[ch]            = 1'b1;
      ch_type[ch*4 +: 4]      = 4'(ch + 1);
      ch_shares[ch*32 +: 32]  = 32'(shares);
      ch_misc[ch*64 +: 64]    = 64'hA5A5_0000_0000_0000 | 64'(shares);
      ch_side[ch]             = 1'b1;
      valid_in                = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
      clear_inputs();
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
      checks++; if (msg_cnt !== 4'd0 || collision_cnt !== 4'd0 || overflow_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", msg_cnt, collision_cnt, overflow_cnt); end
      checks++; if (out_shares !== 32'd0 || out_src !== 3'd0 || out_misc !== 64'd0) begin
         errors++; $display("FAIL reset_fields got shares %0d src %0d exp 0", out_shares, out_src); end
      checks++; if (collision_err !== 1'b0 || overflow_err !== 1'b0) begin
         errors++; $display("FAIL reset_flags got %0d%0d exp 00", collision_err, overflow_err); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      push_ch(2, 500);
      tick();
      clear_inputs();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0d exp 1", out_valid); end
      checks++; if (out_shares !== 32'd500) begin errors++; $display("FAIL single_shares got %0d exp 500", out_shares); end
      checks++; if (out_src !== 3'd2) begin errors++; $display("FAIL single_src got %0d exp 2", out_src); end
      checks++; if (out_type !== 4'd3 || out_side !== 1'b1) begin errors++; $display("FAIL single_type got %0d side %0d exp 3 1", out_type, out_side); end
      checks++; if (out_misc !== 64'hA5A5_0000_0000_01F4) begin errors++; $display("FAIL single_misc got %h exp a5a50000000001f4", out_misc); end
      checks++; if (msg_cnt !== 4'd1) begin errors++; $display("FAIL single_msg got %0d exp 1", msg_cnt); end
      tick();
      checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL single_pop got valid %0d level %0d exp 0 0", out_valid, fifo_level); end
   endtask

   task automatic test_collision();
      out_ready = 1'b1;
      push_ch(0, 7);
      ch_valid = 6'b000011;
      tick();
      clear_inputs();
      checks++; if (collision_cnt !== 4'd1 || collision_err !== 1'b1) begin
         errors++; $display("FAIL coll_cnt got %0d err %0d exp 1 1", collision_cnt, collision_err); end
`ifdef PARSER_COLLISION_PRIORITY_EN
      checks++; if (out_valid !== 1'b1 || out_src !== 3'd0 || out_shares !== 32'd7) begin
         errors++; $display("FAIL coll_prio got valid %0d src %0d exp 1 0", out_valid, out_src); end
      checks++; if (msg_cnt !== 4'd2) begin errors++; $display("FAIL coll_msg got %0d exp 2", msg_cnt); end
`else
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_drop got valid %0d exp 0", out_valid); end
      checks++; if (msg_cnt !== 4'd1) begin errors++; $display("FAIL coll_msg got %0d exp 1", msg_cnt); end
`endif
      tick();
      push_ch(3, 77);
      valid_in = 1'b0;
      tick();
      clear_inputs();
      checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL gated_level got %0d exp 0", fifo_level); end
   endtask

   task automatic test_overflow();
      pulse_clr();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_ch(i + 1, 10 + i);
         tick();
         checks++; if (out_valid !== 1'b1 || out_shares !== 32'd10 || out_src !== 3'd1) begin
            errors++; $display("FAIL ovf_head%0d got shares %0d src %0d exp 10 1", i, out_shares, out_src); end
      end
      clear_inputs();
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
      checks++; if (overflow_cnt !== 4'd1 || overflow_err !== 1'b1) begin
         errors++; $display("FAIL ovf_cnt got %0d err %0d exp 1 1", overflow_cnt, overflow_err); end
      checks++; if (msg_cnt !== 4'd4) begin errors++; $display("FAIL ovf_msg got %0d exp 4", msg_cnt); end
   endtask

   task automatic test_full_pop();
      int exp_q [4];
      exp_q = '{11, 12, 13, 20};
      out_ready = 1'b1;
      push_ch(0, 20);
      tick();
      clear_inputs();
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d exp 4", fifo_level); end
      checks++; if (msg_cnt !== 4'd5 || overflow_cnt !== 4'd1) begin
         errors++; $display("FAIL fullpop_cnt got msg %0d ovf %0d exp 5 1", msg_cnt, overflow_cnt); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1 || out_shares !== 32'(exp_q[k])) begin
            errors++; $display("FAIL drain%0d got %0d exp %0d", k, out_shares, exp_q[k]); end
         tick();
      end
      checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         errors++; $display("FAIL drain_empty got valid %0d level %0d exp 0 0", out_valid, fifo_level); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_ch(4, 30 + i);
         tick();
         checks++; if (fifo_level !== 3'd1 || out_shares !== 32'(30 + i) || out_src !== 3'd4) begin
            errors++; $display("FAIL b2b%0d got level %0d shares %0d exp 1 %0d", i, fifo_level, out_shares, 30 + i); end
      end
      clear_inputs();
      tick();
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", fifo_level); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_ch(5, 40 + i);
         tick();
      end
      clear_inputs();
      checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d exp 3", fifo_level); end
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         errors++; $display("FAIL mid_async got valid %0d level %0d exp 0 0", out_valid, fifo_level); end
      checks++; if (msg_cnt !== 4'd0 || overflow_cnt !== 4'd0 || overflow_err !== 1'b0) begin
         errors++; $display("FAIL mid_cnt got msg %0d ovf %0d exp 0 0", msg_cnt, overflow_cnt); end
      checks++; if (out_shares !== 32'd0) begin errors++; $display("FAIL mid_fields got %0d exp 0", out_shares); end
      tick();
      rst = 1'b1;
      push_ch(3, 50);
      tick();
      clear_inputs();
      checks++; if (fifo_level !== 3'd1 || out_shares !== 32'd50 || out_src !== 3'd3) begin
         errors++; $display("FAIL mid_resume got level %0d shares %0d exp 1 50", fifo_level, out_shares); end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_saturation();
      pulse_clr();
      out_ready = 1'b1;
      push_ch(0, 60);
      ch_valid = 6'b000011;
      repeat (20) tick();
      checks++; if (collision_cnt !== 4'd15 || collision_err !== 1'b1) begin
         errors++; $display("FAIL sat_coll got %0d err %0d exp 15 1", collision_cnt, collision_err); end
`ifdef PARSER_COLLISION_PRIORITY_EN
      checks++; if (msg_cnt !== 4'd15) begin errors++; $display("FAIL sat_msg got %0d exp 15", msg_cnt); end
`else
      checks++; if (msg_cnt !== 4'd0) begin errors++; $display("FAIL sat_msg got %0d exp 0", msg_cnt); end
`endif
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      checks++; if (collision_cnt !== 4'd0 || collision_err !== 1'b0 || msg_cnt !== 4'd0) begin
         errors++; $display("FAIL sat_clr got coll %0d err %0d msg %0d exp 0 0 0", collision_cnt, collision_err, msg_cnt); end
      tick();
      checks++; if (collision_cnt !== 4'd1) begin errors++; $display("FAIL sat_after_clr got %0d exp 1", collision_cnt); end
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_collision();
      test_overflow();
      test_full_pop();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
